// File: rtl/horner_pkg.sv
// Shared types and fixed-point helpers for the Horner polynomial pipeline.
// Values travel between stages sign-extended to MAX_W bits. The owning module
// narrows them back to its DATA_W, so any DATA_W <= MAX_W is supported.
// Build option: HORNER_POLY_SAT_EN selects saturating stage arithmetic
// (default: two's-complement wrap).
package horner_pkg;

  localparam int unsigned MAX_W  = 64;
  localparam int unsigned PROD_W = 2 * MAX_W;

  typedef logic signed [MAX_W-1:0]  fx_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  // One pipeline stage record: sample, running accumulator, frame end, overflow.
  typedef struct packed {
    logic valid;
    fx_t  x;
    fx_t  acc;
    logic last;
    logic ovf;
  } stage_t;

  typedef struct packed {
    logic ovf;
    fx_t  val;
  } sum_t;

  // Full-precision product, arithmetic shift right (truncates toward -inf).
  function automatic prod_t fx_mul_shift(input fx_t a, input fx_t b,
                                         input int unsigned frac_w);
    prod_t p;
    p = prod_t'(a) * prod_t'(b);
    return p >>> frac_w;
  endfunction

  // Add the coefficient to a shifted product and reduce the result to data_w bits.
  function automatic sum_t fx_sat_add(input prod_t p, input fx_t c,
                                      input int unsigned data_w);
    sum_t r;
`ifdef HORNER_POLY_SAT_EN
    prod_t hi;
    prod_t lo;
    prod_t s;
    hi    = (prod_t'(1) <<< (data_w - 1)) - prod_t'(1);
    lo    = -hi - prod_t'(1);
    r.ovf = 1'b0;
    s     = p;
    // Clamp the product first so the following add stays within data_w+1 bits.
    if (s > hi) begin
      s     = hi;
      r.ovf = 1'b1;
    end else if (s < lo) begin
      s     = lo;
      r.ovf = 1'b1;
    end
    s = s + prod_t'(c);
    if (s > hi) begin
      s     = hi;
      r.ovf = 1'b1;
    end else if (s < lo) begin
      s     = lo;
      r.ovf = 1'b1;
    end
    r.val = fx_t'(s);
`else
    prod_t s;
    fx_t   v;
    s     = p + prod_t'(c);
    v     = fx_t'(s);
    // Keep the low data_w bits and sign-extend them back to MAX_W.
    v     = (v <<< (MAX_W - data_w)) >>> (MAX_W - data_w);
    r.ovf = 1'b0;
    r.val = v;
`endif
    return r;
  endfunction

endpackage

// File: rtl/horner_mac_stage.sv
// One Horner pipeline register stage: acc = f(prev.acc * prev.x) + COEFF_K.
// Ports: clk, rst (sync, active-high), adv (global advance), prev (upstream
// stage record), cur (this stage's registered record, sign-extended to MAX_W).
// Build option: HORNER_POLY_SAT_EN (see horner_pkg).
module horner_mac_stage
  import horner_pkg::*;
#(
  parameter int unsigned               DATA_W  = 32,
  parameter int unsigned               FRAC_W  = 16,
  parameter logic signed [DATA_W-1:0]  COEFF_K = '0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   adv,
  input  stage_t prev,
  output stage_t cur
);

  logic                     valid;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] acc;
  logic                     last;
  logic                     ovf;
  sum_t                     sum_c;
  logic                     unused_sum;

  // Multiply-shift-add of the upstream record.
  always_comb begin
    sum_c = fx_sat_add(fx_mul_shift(prev.acc, prev.x, FRAC_W), fx_t'(COEFF_K), DATA_W);
  end

  // Only the low DATA_W bits of the reduced sum are kept; the rest are sign copies.
  assign unused_sum = ^sum_c.val;

  // Stage register: loads on advance, bubbles are carried with zeroed data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      x     <= '0;
      acc   <= '0;
      last  <= 1'b0;
      ovf   <= 1'b0;
    end else if (adv) begin
      valid <= prev.valid;
      if (prev.valid) begin
        x    <= prev.x[DATA_W-1:0];
        acc  <= sum_c.val[DATA_W-1:0];
        last <= prev.last;
        ovf  <= prev.ovf | sum_c.ovf;
      end else begin
        x    <= '0;
        acc  <= '0;
        last <= 1'b0;
        ovf  <= 1'b0;
      end
    end
  end

  assign cur = '{valid: valid, x: fx_t'(x), acc: fx_t'(acc), last: last, ovf: ovf};

endmodule

// File: rtl/horner_poly_stream.sv
// Fully pipelined AXI-Stream polynomial evaluator using Horner's rule:
// y = C[0]*x^D + ... + C[D], signed Q(DATA_W-FRAC_W).FRAC_W, DEGREE stages.
// Ports: clk, rst (sync, active-high); s_tvalid/s_tready/s_tdata/s_tlast
// (x input); m_tvalid/m_tready/m_tdata/m_tlast/m_tuser (y output, m_tuser =
// overflow seen in any stage). s_tready is combinational from m_tready.
// Build option: HORNER_POLY_SAT_EN enables saturation and m_tuser; without it
// results wrap and m_tuser is 0. DATA_W must not exceed horner_pkg::MAX_W.
module horner_poly_stream
  import horner_pkg::*;
#(
  parameter int unsigned              DATA_W = 32,
  parameter int unsigned              FRAC_W = 16,
  parameter int unsigned              DEGREE = 3,
  parameter logic signed [DATA_W-1:0] COEFF [DEGREE+1] = '{default: '0}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              m_tuser
);

  stage_t pipe [DEGREE+1];
  logic   adv;
  logic   unused_tail;

  // Whole pipe moves together whenever the output slot is empty or being taken.
  assign adv      = !m_tvalid || m_tready;
  assign s_tready = adv;

  // Stage 1 sees the leading coefficient as its incoming accumulator.
  assign pipe[0] = '{valid: s_tvalid, x: fx_t'($signed(s_tdata)), acc: fx_t'(COEFF[0]),
                     last: s_tlast, ovf: 1'b0};

  for (genvar k = 1; k <= int'(DEGREE); k++) begin : g_stage
    horner_mac_stage #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .COEFF_K(COEFF[k])
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .adv (adv),
      .prev(pipe[k-1]),
      .cur (pipe[k])
    );
  end

  assign m_tvalid = pipe[DEGREE].valid;
  assign m_tdata  = pipe[DEGREE].acc[DATA_W-1:0];
  assign m_tlast  = pipe[DEGREE].last;
`ifdef HORNER_POLY_SAT_EN
  assign m_tuser  = pipe[DEGREE].ovf;
`else
  assign m_tuser  = 1'b0;
`endif

  // The final x and the sign-extension bits of the last stage are not needed.
  assign unused_tail = ^{pipe[DEGREE].x, pipe[DEGREE].acc, pipe[DEGREE].ovf};

endmodule
